// File: rtl/uart_pkt_tx.sv
// ============================================================================
// Module   : uart_pkt_tx
// Purpose  : Packet-level UART transmitter. Accepts one W_OUT-bit packet on a
//            valid/ready handshake and sends it as NUM_WORDS back-to-back UART
//            frames (start, data LSB first, optional parity, stop), word 0
//            first.
// Options  : UART_PARITY_EN - when defined, an even-parity bit is inserted
//            between the data bits and the stop bit of every frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_pkt_tx #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 16
) (
  input  logic                                                   clk,
  input  logic                                                   rstn,
  input  logic                                                   s_valid,
  input  logic [W_OUT/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0]      s_data,
  output logic                                                   s_ready,
  output logic                                                   tx,
  output logic                                                   busy
);

  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CNT_W     = $clog2(CLOCKS_PER_PULSE);
  localparam int BIT_W     = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BIT_W-1:0]    bit_q;
  logic [WORD_W-1:0]   word_q;
  logic [W_OUT-1:0]    pkt_q;
  logic                tx_q;
  logic                ready_q;
  logic                busy_q;

  // The word being sent always sits in the low bits of the packet register;
  // it is shifted down by one word at each stop-to-start transition.
  logic [BITS_PER_WORD-1:0] cur_word;
  logic [BIT_W-1:0]         bit_d;
  logic [CNT_W-1:0]         cnt_d;

  assign cur_word = pkt_q[BITS_PER_WORD-1:0];
  assign bit_d    = bit_q + 1'b1;
  assign cnt_d    = cnt_q + 1'b1;

  // Framing FSM: bit-time counter, bit/word indices and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      pkt_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // ready_q is high throughout IDLE, so s_valid alone completes the handshake.
          if (s_valid) begin
            pkt_q   <= s_data;
            word_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_START;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_d;
          end else begin
            cnt_q <= '0;
            case (state_q)
              ST_START: begin
                state_q <= ST_DATA;
                bit_q   <= '0;
                tx_q    <= cur_word[0];
              end
              ST_DATA: begin
                if (bit_q != BIT_LAST) begin
                  bit_q <= bit_d;
                  tx_q  <= cur_word[bit_d];
                end else begin
                  bit_q <= '0;
`ifdef UART_PARITY_EN
                  state_q <= ST_PARITY;
                  tx_q    <= ^cur_word;
`else
                  state_q <= ST_STOP;
                  tx_q    <= 1'b1;
`endif
                end
              end
`ifdef UART_PARITY_EN
              ST_PARITY: begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
`endif
              ST_STOP: begin
                if (word_q != WORD_LAST) begin
                  // Next frame starts immediately, no idle gap between words.
                  word_q  <= word_q + 1'b1;
                  pkt_q   <= pkt_q >> BITS_PER_WORD;
                  state_q <= ST_START;
                  tx_q    <= 1'b0;
                end else begin
                  state_q <= ST_IDLE;
                  tx_q    <= 1'b1;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                end
              end
              default: begin
                state_q <= ST_IDLE;
                tx_q    <= 1'b1;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign s_ready = ready_q;
  assign tx      = tx_q;
  assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_pkt_tx.sv
// ============================================================================
// Module   : tb_uart_pkt_tx
// Purpose  : Self-checking bench for uart_pkt_tx (CLOCKS_PER_PULSE=4, 8-bit
//            words, 16-bit packets). Honours UART_PARITY_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_pkt_tx;

  localparam int CPP = 4;
  localparam int BPW = 8;
  localparam int WO  = 16;
  localparam int NW  = WO / BPW;
`ifdef UART_PARITY_EN
  localparam int FL  = (BPW + 3) * CPP;
`else
  localparam int FL  = (BPW + 2) * CPP;
`endif

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic                     s_valid = 1'b0;
  logic [NW-1:0][BPW-1:0]   s_data = '0;
  logic                     s_ready;
  logic                     tx;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_pkt_tx #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD(BPW),
    .W_OUT(WO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .tx(tx),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level for every cycle of the packet, built frame by frame.
  task automatic build_exp(input logic [WO-1:0] pkt);
    exp_q.delete();
    for (int w = 0; w < NW; w++) begin
      int unsigned word;
      bit frame[$];
      word = (int'(pkt) >> (w * BPW)) & ((1 << BPW) - 1);
      frame.push_back(1'b0);
      for (int b = 0; b < BPW; b++) frame.push_back(((word >> b) & 1) != 0);
`ifdef UART_PARITY_EN
      frame.push_back(($countones(word) % 2) != 0);
`endif
      frame.push_back(1'b1);
      foreach (frame[i]) begin
        for (int c = 0; c < CPP; c++) exp_q.push_back(frame[i]);
      end
    end
  endtask

  // Offer pkt, then follow the line cycle by cycle. With hold set, s_valid
  // stays high and s_data switches to nxt right after the accept edge.
  task automatic send_pkt(input logic [WO-1:0] pkt, input bit hold,
                          input logic [WO-1:0] nxt, input bit disturb);
    int waited = 0;
    while (s_ready !== 1'b1 && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("accept_ready", {31'd0, s_ready}, 32'd1);
    if (s_ready !== 1'b1) return;
    build_exp(pkt);
    s_valid = 1'b1;
    s_data  = pkt;
    @(posedge clk); #1;
    if (hold) s_data = nxt;
    else      s_valid = 1'b0;
    for (int k = 0; k < NW * FL; k++) begin
      chk("tx_bit", {31'd0, tx}, {31'd0, exp_q[k]});
      chk("ready_low", {31'd0, s_ready}, 32'd0);
      chk("busy_high", {31'd0, busy}, 32'd1);
      if (disturb && k == FL + 5) begin
        s_data  = WO'($urandom);
        s_valid = 1'b1;
      end
      if (disturb && k == FL + 9) s_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("ready_rise", {31'd0, s_ready}, 32'd1);
    chk("tx_idle", {31'd0, tx}, 32'd1);
    chk("busy_low", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;

    // Directed packets: basic, parity-oriented values.
    send_pkt(16'hA53C, 1'b0, 16'h0000, 1'b0);
    send_pkt(16'h0701, 1'b0, 16'h0000, 1'b0);

    // Back-to-back with s_valid held high.
    send_pkt(16'h1234, 1'b1, 16'hBEEF, 1'b0);
    send_pkt(16'hBEEF, 1'b0, 16'h0000, 1'b0);

    // Input changes and valid pulse while a packet is in flight.
    send_pkt(16'h5AC3, 1'b0, 16'h0000, 1'b1);

    // Random packets, some with random mid-packet disturbance.
    for (int n = 0; n < 6; n++) begin
      send_pkt(WO'($urandom), 1'b0, 16'h0000, bit'($urandom_range(0, 1)));
    end

    // Reset during DATA of word 1.
    s_valid = 1'b1;
    s_data  = 16'hC0DE;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (FL + 2 * CPP) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rstn    = 1'b0;
    s_valid = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_ready", {31'd0, s_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    // Reset wins over a handshake on the same edge.
    @(posedge clk); #1;
    chk("rstprio_ready", {31'd0, s_ready}, 32'd1);
    chk("rstprio_tx", {31'd0, tx}, 32'd1);
    s_valid = 1'b0;
    rstn    = 1'b1;
    @(posedge clk); #1;
    send_pkt(16'h3C5A, 1'b0, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_pkt_tx.md
# uart_pkt_tx

Packet-level UART transmitter: accepts one W_OUT-bit packet on a valid/ready handshake and serializes it as NUM_WORDS back-to-back UART frames on `tx`. It is the transmit-side counterpart to the multi-word receiver `uart_rx` (`m_valid`/`m_data`) and is meant to drive the same serial line format. Pairing it with `uart_rx` gives a self-checking loopback.

## Interface
- `CLOCKS_PER_PULSE`, 5208, clock cycles per serial bit; must be ≥ 2.
- `BITS_PER_WORD`, 8, data bits per UART frame.
- `W_OUT`, 16, packet width; must be a multiple of BITS_PER_WORD.
- `NUM_WORDS` (localparam), W_OUT/BITS_PER_WORD, number of frames per packet.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  packet offered.
- `s_data`  in  [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  packet; word 0 is sent first.
- `s_ready`  out  1  registered; high only in IDLE.
- `tx`  out  1  registered serial line; idles high.
- `busy`  out  1  registered; equals !s_ready.

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP. PARITY exists only when UART_PARITY_EN is defined.
- IDLE:
  - `tx`=1, `s_ready`=1.
  - When `s_valid && s_ready` on an edge, capture the whole `s_data` into an internal shift register, clear the word index, and go to START.
- START: `tx`=0 for one bit time, then go to DATA.
- DATA:
  - Send BITS_PER_WORD bits, LSB first.
  - The bit counter runs 0..BITS_PER_WORD-1.
  - After the last bit, go to PARITY (if enabled) or to STOP.
- PARITY: `tx` = XOR of the current word's data bits (even parity) for one bit time, then go to STOP.
- STOP:
  - `tx`=1 for one bit time.
  - If the word index is below NUM_WORDS-1: increment it and go to START, with no extra idle between frames.
  - Otherwise go to IDLE.
- Bit time is exactly CLOCKS_PER_PULSE cycles.
  - The clock counter runs 0..CLOCKS_PER_PULSE-1 and wraps to 0 at every bit boundary.
  - The counter width is $clog2(CLOCKS_PER_PULSE).
- `s_data` is sampled only on the accept edge. Later changes have no effect on the packet in flight.
- `s_valid` is ignored outside IDLE.
- Reset, including mid-frame:
  - On the next edge, state goes to IDLE, `tx`=1, `s_ready`=1, `busy`=0, and all counters are 0.
  - Any partial frame is abandoned.
  - Reset takes priority over any handshake on the same edge.

## Timing
- Reset values: `tx`=1, `s_ready`=1, `busy`=0.
- Accept edge E0:
  - From the cycle after E0, `tx`=0 and `s_ready`=0.
  - The start bit occupies cycles E0+1 .. E0+CLOCKS_PER_PULSE.
- Frame length F:
  - F = (BITS_PER_WORD+2)·CLOCKS_PER_PULSE without parity.
  - F = (BITS_PER_WORD+3)·CLOCKS_PER_PULSE with parity.
- The packet occupies NUM_WORDS·F cycles. `s_ready` returns to 1 in cycle E0 + NUM_WORDS·F + 1.
- Back-to-back packets: if `s_valid` is held high, the next accept happens in that first IDLE cycle. The line then idles high for the stop bit plus exactly 1 cycle before the next start bit.

## Configuration
- `UART_PARITY_EN`
  - Defined: an even-parity bit is inserted between the data bits and the stop bit of every frame, and F grows by CLOCKS_PER_PULSE.
  - Undefined: there is no PARITY state or parity logic, and the frame is 8N1-style (start, data, stop).

## Test plan
- Reset: hold `rstn`=0 for 3 cycles → `tx`=1, `s_ready`=1, `busy`=0.
- Basic packet, CLOCKS_PER_PULSE=4, no parity:
  - Stimulus: send `s_data`=16'hA53C.
  - `tx` carries frame 0x3C (bits 0,0,1,1,1,1,0,0) then frame 0xA5 (bits 1,0,1,0,0,1,0,1), each bit held 4 cycles.
  - `s_ready` rises at E0+81.
- Parity, UART_PARITY_EN, CLOCKS_PER_PULSE=4:
  - Stimulus: send 16'h0701.
  - Parity bit is 1 for word 0x01 and 1 for word 0x07.
  - `s_ready` rises at E0+89.
- Back-to-back: hold `s_valid` high with 16'h1234, then 16'hBEEF → the second start bit begins exactly 1 cycle after the first packet's final stop bit ends.
- Input stability: change `s_data` and pulse `s_valid` mid-packet → the transmitted bits are unchanged and no second accept occurs.
- Reset mid-frame: assert `rstn`=0 during DATA of word 1 → the next cycle `tx`=1, `s_ready`=1, and a new packet sent afterwards transmits cleanly.
